mem_stage_nb: RTL and testbench
===============================

# mem_stage_nb

Non-blocking memory stage for the five-stage MIPS pipeline, sitting between EXE and WB and successor to the single-request MEM stage. It keeps up to `DEPTH` instructions in an in-order queue, so several data-SRAM requests can be outstanding. It matches in-order `data_ok` responses to their entries, formats load data (byte, half, word, LWL, LWR) and retires to WB in program order. On a pipeline flush it drains responses for cancelled requests without stalling new issue logic.

## Interface
- `DEPTH`, 2, queue entries and max in-flight SRAM requests; power of 2, ≥2.
- `AW`, 32, width of PC / ALU result / data.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `es_valid`  in  1  EXE presents an instruction.
- `ms_allowin`  out  1  queue accepts this cycle.
- `es_req_sent`  in  1  EXE issued a data-SRAM request for this instruction (load or store).
- `es_load_op`  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR.
- `es_addr_lo`  in  2  address bits [1:0].
- `es_gr_we`  in  4  byte write mask for non-loads.
- `es_dest`  in  5  destination register.
- `es_result`  in  AW  ALU result.
- `es_pc`  in  AW  PC.
- `data_sram_data_ok`  in  1  one response, in issue order.
- `data_sram_rdata`  in  32  response data.
- `flush`  in  1  exception/ERET/refetch from WB; cancels all queued entries.
- `ms_to_ws_valid`  out  1  head entry ready to retire.
- `ws_allowin`  in  1  WB accepts.
- `ms_pc`, `ms_dest`, `ms_gr_we`, `ms_result`  out  AW/5/4/32  head fields; `ms_result` is the formatted load data or the ALU result.
- `ms_fwd_busy`  out  1  a queued load whose data has not arrived writes `fwd_dest`; ID must stall.
- `fwd_dest`  in  5  ID source register queried for `ms_fwd_busy`.
- `ms_inflight`  out  clog2(DEPTH+1)  requests issued but not yet answered (live + discard).

## Operation
- Circular queue: `head` and `tail` pointers of clog2(DEPTH) bits plus a `count` register. Each entry holds `mem`, `done`, `load_op`, `addr_lo`, `gr_we`, `dest`, `result` and `pc`.
- Push requires `es_valid && ms_allowin`.
  - `ms_allowin = !flush && count<DEPTH && (!es_req_sent || ms_inflight<DEPTH)`.
  - No push when full, even if the head pops in the same cycle.
  - On push, `mem=es_req_sent` and `done=!es_req_sent`.
- Response routing:
  - If `discard>0`, `data_ok` decrements `discard` and the data is dropped.
  - Otherwise `data_ok` sets `done` on the oldest entry with `mem && !done` and overwrites its `result` with the formatted rdata. A store's rdata is ignored; its `result` is kept.
- Load formatting (`load_align`):
  - LB/LBU select the byte at `addr_lo` and sign-/zero-extend it.
  - LH/LHU select the half at `addr_lo[1]` and sign-/zero-extend it.
  - LW passes the word through.
  - LWL: shift rdata left by 8·(3−addr_lo); `gr_we` = 1000/1100/1110/1111 for addr_lo 0..3.
  - LWR: shift rdata right by 8·addr_lo; `gr_we` = 1111/0111/0011/0001 for addr_lo 0..3.
  - Non-loads use `es_gr_we`.
- Retire: `ms_to_ws_valid = count>0 && head.done && !flush`. A pop happens on `ms_to_ws_valid && ws_allowin`.
- Flush (takes priority over push and pop):
  - `count`, `head` and `tail` are cleared.
  - `discard_next = discard + (#entries with mem && !done) − (data_ok ? 1 : 0)`. A same-cycle `data_ok` is counted against pre-flush state and never writes an entry.
- `ms_inflight = discard + (#entries with mem && !done)`. The counter never exceeds DEPTH; a violation is an assertion failure.

## Timing
- Reset values: queue empty, `discard=0`, `ms_to_ws_valid=0`, `ms_allowin=1`, `ms_fwd_busy=0`, `ms_inflight=0`. Head field outputs are don't-care while `ms_to_ws_valid=0`.
- Non-memory entry: pushed at edge N, `ms_to_ws_valid` is asserted in cycle N+1 if it is at the head.
- Load: `data_ok` at edge M, formatted data is retire-ready in cycle M+1. There is no combinational rdata-to-WB path.
- `ms_fwd_busy` is combinational on `fwd_dest` and the queue state. `fwd_dest==0` never reports busy.
- Reset mid-operation clears `discard`. The SRAM side is reset in the same cycle.

## Structure
- `mem_pkg` holds:
  - the `load_op_t` encoding;
  - the `ms_entry_t` struct;
  - the LWL/LWR write-mask constants.
- Sub-module `load_align`: combinational formatter taking rdata, op and addr_lo, producing result and wen.
- The queue and counters live in the top module.

## Test plan
- LW at PC 0xBFC00000, `data_ok` 3 cycles later with rdata 0x12345678 → one retire with result 0x12345678, `gr_we`=1111, `dest` unchanged.
- LB with addr_lo=2 on rdata 0x00800000 → result 0xFFFFFF80. LBU with the same inputs → 0x00000080.
- LWL with addr_lo=1 on rdata 0xAABBCCDD → result 0xCCDD0000, wen 1100. LWR with addr_lo=1 → result 0x00AABBCC, wen 0111.
- DEPTH=2: two LWs pushed back-to-back → `ms_allowin` low. Responses A then B → retire order A, B. A following ALU op is accepted after the first pop.
- Two loads in flight, `flush` asserted together with the first `data_ok` → queue empty and `discard=1`. The next `data_ok` is dropped. A new LW's response then retires correctly.
- WB holds `ws_allowin=0` for 4 cycles with the head done → the head is held stable, no loss, and the queue fills to DEPTH then backpressures EXE.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and write-mask constants for the non-blocking memory stage.
package mem_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LB   = 3'd1,
        OP_LBU  = 3'd2,
        OP_LH   = 3'd3,
        OP_LHU  = 3'd4,
        OP_LW   = 3'd5,
        OP_LWL  = 3'd6,
        OP_LWR  = 3'd7
    } load_op_t;

    typedef struct packed {
        logic        mem;
        logic        done;
        load_op_t    load_op;
        logic [1:0]  addr_lo;
        logic [3:0]  gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_entry_t;

    // nibble k holds the mask for addr_lo == k
    localparam logic [15:0] LWL_WEN = 16'b1111_1110_1100_1000;
    localparam logic [15:0] LWR_WEN = 16'b0001_0011_0111_1111;

    function automatic logic [3:0] lwl_wen(input logic [1:0] a);
        return LWL_WEN[{a, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] lwr_wen(input logic [1:0] a);
        return LWR_WEN[{a, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: formats raw SRAM read data for byte/half/word/LWL/LWR loads.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  load_op_t    op,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  gr_in,
    output logic [31:0] result,
    output logic [3:0]  wen
);

    logic [31:0] shr;
    logic [15:0] half;

    assign shr  = rdata >> {addr_lo, 3'b000};
    assign half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    assign result = op == OP_LB  ? {{24{shr[7]}}, shr[7:0]} :
                    op == OP_LBU ? {24'b0, shr[7:0]} :
                    op == OP_LH  ? {{16{half[15]}}, half} :
                    op == OP_LHU ? {16'b0, half} :
                    op == OP_LWL ? rdata << {~addr_lo, 3'b000} :
                    op == OP_LWR ? shr : rdata;

    assign wen = op == OP_LWL ? lwl_wen(addr_lo) :
                 op == OP_LWR ? lwr_wen(addr_lo) : gr_in;

endmodule

// File: rtl/mem_stage_nb.sv
// mem_stage_nb: in-order queue of up to DEPTH instructions with outstanding data-SRAM
// requests; matches in-order responses, formats loads, retires to WB, drains after flush.
module mem_stage_nb
    import mem_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_valid,
    output logic                       ms_allowin,
    input  logic                       es_req_sent,
    input  logic [2:0]                 es_load_op,
    input  logic [1:0]                 es_addr_lo,
    input  logic [3:0]                 es_gr_we,
    input  logic [4:0]                 es_dest,
    input  logic [AW-1:0]              es_result,
    input  logic [AW-1:0]              es_pc,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       flush,
    output logic                       ms_to_ws_valid,
    input  logic                       ws_allowin,
    output logic [AW-1:0]              ms_pc,
    output logic [4:0]                 ms_dest,
    output logic [3:0]                 ms_gr_we,
    output logic [31:0]                ms_result,
    output logic                       ms_fwd_busy,
    input  logic [4:0]                 fwd_dest,
    output logic [$clog2(DEPTH+1)-1:0] ms_inflight
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    ms_entry_t     q [DEPTH];
    logic [PW-1:0] head, tail, hit, idx;
    logic [CW-1:0] count, discard, pend;
    logic          hit_ok, push, pop;
    logic [31:0]   al_result;
    logic [3:0]    al_wen;

    // hit is the oldest live entry still waiting on its response
    always_comb begin
        pend        = '0;
        hit         = head;
        hit_ok      = 1'b0;
        ms_fwd_busy = 1'b0;
        idx         = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && q[idx].mem && !q[idx].done) begin
                pend = pend + CW'(1);
                if (!hit_ok) begin
                    hit    = idx;
                    hit_ok = 1'b1;
                end
                if (q[idx].load_op != OP_NONE && q[idx].dest == fwd_dest && fwd_dest != 5'd0)
                    ms_fwd_busy = 1'b1;
            end
        end
    end

    assign ms_inflight    = discard + pend;
    assign ms_allowin     = !flush && count < CW'(DEPTH) && (!es_req_sent || ms_inflight < CW'(DEPTH));
    assign ms_to_ws_valid = count != '0 && q[head].done && !flush;
    assign push           = es_valid && ms_allowin;
    assign pop            = ms_to_ws_valid && ws_allowin;

    assign ms_pc     = q[head].pc;
    assign ms_dest   = q[head].dest;
    assign ms_gr_we  = q[head].gr_we;
    assign ms_result = q[head].result;

    load_align u_align (
        .rdata  (data_sram_rdata),
        .op     (q[hit].load_op),
        .addr_lo(q[hit].addr_lo),
        .gr_in  (q[hit].gr_we),
        .result (al_result),
        .wen    (al_wen)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            discard <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            discard <= discard + pend - CW'(data_sram_data_ok);
        end else begin
            if (data_sram_data_ok) begin
                if (discard != '0)
                    discard <= discard - CW'(1);
                else if (hit_ok) begin
                    q[hit].done <= 1'b1;
                    if (q[hit].load_op != OP_NONE) begin
                        q[hit].result <= al_result;
                        q[hit].gr_we  <= al_wen;
                    end
                end
            end
            if (push) begin
                q[tail] <= '{mem: es_req_sent, done: !es_req_sent, load_op: load_op_t'(es_load_op),
                             addr_lo: es_addr_lo, gr_we: es_gr_we, dest: es_dest,
                             result: es_result, pc: es_pc};
                tail <= tail + PW'(1);
            end
            if (pop)
                head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    a_inflight_bound: assert property (@(posedge clk) disable iff (reset) ms_inflight <= CW'(DEPTH));

endmodule

// File: tb/tb_mem_stage_nb.sv
// tb_mem_stage_nb: directed scoreboard bench; stimulus queues expected retirements,
// a negedge monitor compares each WB handoff in order.
module tb_mem_stage_nb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        es_valid = 1'b0, es_req_sent = 1'b0;
    logic [2:0]  es_load_op = '0;
    logic [1:0]  es_addr_lo = '0;
    logic [3:0]  es_gr_we = '0;
    logic [4:0]  es_dest = '0, fwd_dest = '0;
    logic [31:0] es_result = '0, es_pc = '0;
    logic        data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = '0;
    logic        flush = 1'b0, ws_allowin = 1'b1;
    logic        ms_allowin, ms_to_ws_valid, ms_fwd_busy;
    logic [31:0] ms_pc, ms_result;
    logic [4:0]  ms_dest;
    logic [3:0]  ms_gr_we;
    logic [1:0]  ms_inflight;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [3:0]  we;
        logic [31:0] res;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    mem_stage_nb #(.DEPTH(2), .AW(32)) dut (
        .clk(clk), .reset(reset), .es_valid(es_valid), .ms_allowin(ms_allowin),
        .es_req_sent(es_req_sent), .es_load_op(es_load_op), .es_addr_lo(es_addr_lo),
        .es_gr_we(es_gr_we), .es_dest(es_dest), .es_result(es_result), .es_pc(es_pc),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .flush(flush), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_dest(ms_dest), .ms_gr_we(ms_gr_we), .ms_result(ms_result),
        .ms_fwd_busy(ms_fwd_busy), .fwd_dest(fwd_dest), .ms_inflight(ms_inflight)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_retire: got pc=%h result=%h, none expected", ms_pc, ms_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (ms_pc !== e.pc || ms_dest !== e.dest || ms_gr_we !== e.we || ms_result !== e.res) begin
                    errors++;
                    $display("FAIL retire: got pc=%h dest=%0d we=%b res=%h expected pc=%h dest=%0d we=%b res=%h",
                             ms_pc, ms_dest, ms_gr_we, ms_result, e.pc, e.dest, e.we, e.res);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] pc, input logic [2:0] op, input logic [1:0] a,
                         input logic [3:0] we, input logic [4:0] d, input logic [31:0] res,
                         input logic req, input logic [31:0] exp_res, input logic [3:0] exp_we,
                         input bit retires);
        int n = 0;
        es_valid = 1'b1; es_pc = pc; es_load_op = op; es_addr_lo = a;
        es_gr_we = we; es_dest = d; es_result = res; es_req_sent = req;
        #1;
        while (!ms_allowin && n < 20) begin
            step();
            n++;
        end
        if (!ms_allowin) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: pc=%h never accepted", pc);
        end else begin
            if (retires) exp_q.push_back('{pc: pc, dest: d, we: exp_we, res: exp_res});
            step();
        end
        es_valid = 1'b0;
        es_req_sent = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = rdata;
        step();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d retirements outstanding, expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        step(); step();
        reset = 1'b0;
        #1;
        chk("reset_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("reset_allowin", 32'(ms_allowin), 32'd1);
        chk("reset_fwd_busy", 32'(ms_fwd_busy), 32'd0);
        chk("reset_inflight", 32'(ms_inflight), 32'd0);

        // LW with delayed response
        issue(32'hBFC00000, 3'd5, 2'd0, 4'b1111, 5'd5, 32'h0, 1'b1, 32'h12345678, 4'b1111, 1);
        fwd_dest = 5'd5; #1;
        chk("fwd_busy_hit", 32'(ms_fwd_busy), 32'd1);
        fwd_dest = 5'd7; #1;
        chk("fwd_busy_other", 32'(ms_fwd_busy), 32'd0);
        fwd_dest = 5'd0; #1;
        chk("fwd_busy_zero", 32'(ms_fwd_busy), 32'd0);
        chk("lw_inflight", 32'(ms_inflight), 32'd1);
        chk("lw_not_ready", 32'(ms_to_ws_valid), 32'd0);
        step(); step(); step();
        respond(32'h12345678);
        drain("lw");

        // LB / LBU back-to-back fill the queue
        issue(32'h100, 3'd1, 2'd2, 4'b1111, 5'd6, 32'h0, 1'b1, 32'hFFFFFF80, 4'b1111, 1);
        issue(32'h104, 3'd2, 2'd2, 4'b1111, 5'd7, 32'h0, 1'b1, 32'h00000080, 4'b1111, 1);
        chk("full_allowin", 32'(ms_allowin), 32'd0);
        chk("full_inflight", 32'(ms_inflight), 32'd2);
        respond(32'h00800000);
        respond(32'h00800000);
        drain("lb");

        // LWL / LWR
        issue(32'h108, 3'd6, 2'd1, 4'b1111, 5'd8, 32'h0, 1'b1, 32'hCCDD0000, 4'b1100, 1);
        issue(32'h10C, 3'd7, 2'd1, 4'b1111, 5'd9, 32'h0, 1'b1, 32'h00AABBCC, 4'b0111, 1);
        respond(32'hAABBCCDD);
        respond(32'hAABBCCDD);
        drain("lwl");

        // in-order retirement with an ALU op accepted after the first pop
        issue(32'h200, 3'd5, 2'd0, 4'b1111, 5'd10, 32'h0, 1'b1, 32'hAAAA0001, 4'b1111, 1);
        issue(32'h204, 3'd5, 2'd0, 4'b1111, 5'd11, 32'h0, 1'b1, 32'hBBBB0002, 4'b1111, 1);
        chk("two_lw_allowin", 32'(ms_allowin), 32'd0);
        respond(32'hAAAA0001);
        issue(32'h208, 3'd0, 2'd0, 4'b1111, 5'd12, 32'h00001234, 1'b0, 32'h00001234, 4'b1111, 1);
        respond(32'hBBBB0002);
        drain("order");

        // flush together with the first response
        issue(32'h300, 3'd5, 2'd0, 4'b1111, 5'd13, 32'h0, 1'b1, 32'h0, 4'b0, 0);
        issue(32'h304, 3'd5, 2'd0, 4'b1111, 5'd14, 32'h0, 1'b1, 32'h0, 4'b0, 0);
        flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11111111;
        #1;
        chk("flush_allowin", 32'(ms_allowin), 32'd0);
        step();
        flush = 1'b0; data_sram_data_ok = 1'b0;
        #1;
        chk("flush_discard", 32'(ms_inflight), 32'd1);
        chk("flush_empty", 32'(ms_to_ws_valid), 32'd0);
        respond(32'hDEADBEEF);
        chk("discard_done", 32'(ms_inflight), 32'd0);
        chk("discard_no_retire", 32'(ms_to_ws_valid), 32'd0);
        issue(32'h308, 3'd5, 2'd0, 4'b1111, 5'd15, 32'h0, 1'b1, 32'hCAFEBABE, 4'b1111, 1);
        respond(32'hCAFEBABE);
        drain("flush");

        // WB backpressure holds the head and stalls EXE
        ws_allowin = 1'b0;
        issue(32'h400, 3'd0, 2'd0, 4'b1111, 5'd16, 32'h55, 1'b0, 32'h55, 4'b1111, 1);
        issue(32'h404, 3'd0, 2'd0, 4'b0000, 5'd17, 32'h66, 1'b0, 32'h66, 4'b0000, 1);
        chk("bp_allowin", 32'(ms_allowin), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 32'(ms_to_ws_valid), 32'd1);
            chk("bp_head_pc", ms_pc, 32'h400);
            chk("bp_head_res", ms_result, 32'h55);
            step();
        end
        ws_allowin = 1'b1;
        issue(32'h408, 3'd0, 2'd0, 4'b1111, 5'd18, 32'h77, 1'b0, 32'h77, 4'b1111, 1);
        drain("bp");

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
